// File: rtl/ft_tx_scheduler.sv
// Packet scheduler for the FT600 write path: arbitrates IQ and CPU FIFOs and frames each
// granted burst as one header word plus PKT_WORDS payload words.
module ft_tx_scheduler #(
    parameter int FT_DATA_WIDTH    = 32,
    parameter int IQ_PAIR_WIDTH    = 24,
    parameter int QSTART_BIT_INDEX = 12,
    parameter int PKT_WORDS        = 32,
    parameter int MAX_IQ_BURSTS    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_iq_en_i,
    input  logic [IQ_PAIR_WIDTH-1:0] iq_data_i,
    input  logic                     iq_empty_i,
    input  logic                     iq_enough_i,
    output logic                     iq_re_o,
    input  logic [FT_DATA_WIDTH-1:0] cpu_data_i,
    input  logic                     cpu_empty_i,
    input  logic [3:0]               cpu_blkcnt_i,
    output logic                     cpu_re_o,
    output logic                     cpu_blk_done_o,
    output logic [FT_DATA_WIDTH-1:0] ft_data_o,
    output logic                     ft_available_o,
    input  logic                     ft_re_i,
    output logic [1:0]               grant_o,
    output logic                     underrun_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HDR     = 2'd1,
        S_PAYLOAD = 2'd2
    } state_t;

    localparam logic [7:0]  LAST_IDX    = 8'(PKT_WORDS - 1);
    localparam logic [7:0]  PKT_LEN     = 8'(PKT_WORDS);
    localparam logic [31:0] MAX_BURSTS  = 32'(MAX_IQ_BURSTS);

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic       avail_q, avail_d;
    logic [7:0] seq_iq_q, seq_iq_d;
    logic [7:0] seq_cpu_q, seq_cpu_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] starve_q, starve_d;
    logic       underrun_q, underrun_d;
    logic       done_q, done_d;

    logic                     iq_pend_s;
    logic                     cpu_pend_s;
    logic                     starve_hit_s;
    logic                     src_cpu_s;
    logic                     src_empty_s;
    logic                     pop_s;
    logic [11:0]              iq_i_s;
    logic [11:0]              iq_q_s;
    logic [7:0]               seq_sel_s;
    logic [FT_DATA_WIDTH-1:0] data_s;

    assign iq_pend_s    = cfg_iq_en_i & iq_enough_i;
    assign cpu_pend_s   = (cpu_blkcnt_i != 4'd0);
    assign starve_hit_s = ({29'd0, starve_q} >= MAX_BURSTS);
    assign src_cpu_s    = grant_q[1];
    assign src_empty_s  = src_cpu_s ? cpu_empty_i : iq_empty_i;
    assign seq_sel_s    = src_cpu_s ? seq_cpu_q : seq_iq_q;
    assign iq_i_s       = iq_data_i[11:0];
    assign iq_q_s       = iq_data_i[QSTART_BIT_INDEX +: 12];

    // Next-state, framing and pop logic; pops follow ft_re_i in the same cycle
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        avail_d    = avail_q;
        seq_iq_d   = seq_iq_q;
        seq_cpu_d  = seq_cpu_q;
        cnt_d      = cnt_q;
        starve_d   = starve_q;
        underrun_d = underrun_q;
        done_d     = 1'b0;
        pop_s      = 1'b0;
        data_s     = '0;
        case (state_q)
            S_IDLE: begin
                if (iq_pend_s && (!cpu_pend_s || !starve_hit_s)) begin
                    state_d = S_HDR;
                    grant_d = 2'b01;
                    avail_d = 1'b1;
                    if (cpu_pend_s) begin
                        starve_d = (starve_q == 3'd7) ? 3'd7 : starve_q + 3'd1;
                    end else begin
                        starve_d = starve_q;
                    end
                end else if (cpu_pend_s) begin
                    state_d  = S_HDR;
                    grant_d  = 2'b10;
                    avail_d  = 1'b1;
                    starve_d = 3'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HDR: begin
                data_s = {4'hA, src_cpu_s, 3'b000, seq_sel_s, 8'h00, PKT_LEN};
                if (ft_re_i) begin
                    if (src_cpu_s) begin
                        seq_cpu_d = seq_cpu_q + 8'd1;
                    end else begin
                        seq_iq_d = seq_iq_q + 8'd1;
                    end
                    cnt_d   = 8'd0;
                    state_d = S_PAYLOAD;
                end else begin
                    state_d = S_HDR;
                end
            end
            S_PAYLOAD: begin
                if (src_cpu_s) begin
                    data_s = cpu_data_i;
                end else begin
                    data_s = {{4{iq_q_s[11]}}, iq_q_s, {4{iq_i_s[11]}}, iq_i_s};
                end
                pop_s = ft_re_i & ~src_empty_s;
                if (ft_re_i && src_empty_s) begin
                    underrun_d = 1'b1;
                end else begin
                    underrun_d = underrun_q;
                end
                if (pop_s && (cnt_q == LAST_IDX)) begin
                    state_d = S_IDLE;
                    grant_d = 2'b00;
                    avail_d = 1'b0;
                    done_d  = src_cpu_s;
                end else if (pop_s) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
                avail_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any packet in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            grant_q    <= 2'b00;
            avail_q    <= 1'b0;
            seq_iq_q   <= 8'd0;
            seq_cpu_q  <= 8'd0;
            cnt_q      <= 8'd0;
            starve_q   <= 3'd0;
            underrun_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            avail_q    <= avail_d;
            seq_iq_q   <= seq_iq_d;
            seq_cpu_q  <= seq_cpu_d;
            cnt_q      <= cnt_d;
            starve_q   <= starve_d;
            underrun_q <= underrun_d;
            done_q     <= done_d;
        end
    end

    assign ft_data_o      = data_s;
    assign ft_available_o = avail_q;
    assign grant_o        = grant_q;
    assign underrun_o     = underrun_q;
    assign cpu_blk_done_o = done_q;
    assign iq_re_o        = pop_s & ~src_cpu_s;
    assign cpu_re_o       = pop_s & src_cpu_s;

endmodule

// File: tb/tb_ft_tx_scheduler.sv
// Self-checking bench for ft_tx_scheduler: FIFO models feed the DUT and a packet-position
// reference model predicts every output cycle by cycle.
module tb_ft_tx_scheduler;

    localparam int PKT  = 4;
    localparam int MAXB = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_iq_en;
    logic [23:0] iq_data;
    logic        iq_empty, iq_enough, iq_re;
    logic [31:0] cpu_data;
    logic        cpu_empty, cpu_re, blk_done;
    logic [3:0]  cpu_blkcnt;
    logic [31:0] ft_data;
    logic        ft_avail, ft_re, underrun;
    logic [1:0]  grant;

    // second instance with CPU strict priority, driven by static inputs
    logic        b_iq_empty, b_iq_enough, b_cpu_empty, b_ft_re;
    logic [3:0]  b_cpu_blkcnt;
    logic [31:0] b_data;
    logic        b_iq_re, b_cpu_re, b_done, b_avail, b_underrun;
    logic [1:0]  b_grant;

    int n_cmp = 0;
    int n_bad = 0;

    logic [23:0] iq_q[$];
    logic [31:0] cpu_q[$];

    int       m_pos, m_src, m_starve;
    int       m_seq[2];
    logic     m_underrun, m_done;
    logic [6:0]  exp_ctrl;
    logic [31:0] exp_data;
    logic [6:0]  act_ctrl;

    assign act_ctrl = {ft_avail, grant, iq_re, cpu_re, blk_done, underrun};

    always #5 clk = ~clk;

    ft_tx_scheduler #(.PKT_WORDS(PKT), .MAX_IQ_BURSTS(MAXB)) u_dut (
        .clk(clk), .reset(rst), .cfg_iq_en_i(cfg_iq_en),
        .iq_data_i(iq_data), .iq_empty_i(iq_empty), .iq_enough_i(iq_enough), .iq_re_o(iq_re),
        .cpu_data_i(cpu_data), .cpu_empty_i(cpu_empty), .cpu_blkcnt_i(cpu_blkcnt),
        .cpu_re_o(cpu_re), .cpu_blk_done_o(blk_done),
        .ft_data_o(ft_data), .ft_available_o(ft_avail), .ft_re_i(ft_re),
        .grant_o(grant), .underrun_o(underrun)
    );

    ft_tx_scheduler #(.PKT_WORDS(PKT), .MAX_IQ_BURSTS(0)) u_dut0 (
        .clk(clk), .reset(rst), .cfg_iq_en_i(cfg_iq_en),
        .iq_data_i(24'h7FF800), .iq_empty_i(b_iq_empty), .iq_enough_i(b_iq_enough), .iq_re_o(b_iq_re),
        .cpu_data_i(32'h1234_5678), .cpu_empty_i(b_cpu_empty), .cpu_blkcnt_i(b_cpu_blkcnt),
        .cpu_re_o(b_cpu_re), .cpu_blk_done_o(b_done),
        .ft_data_o(b_data), .ft_available_o(b_avail), .ft_re_i(b_ft_re),
        .grant_o(b_grant), .underrun_o(b_underrun)
    );

    function automatic logic [31:0] fmt_iq(logic [23:0] w);
        logic signed [11:0] iv, qv;
        logic signed [15:0] ie, qe;
        iv = w[11:0];
        qv = w[23:12];
        ie = iv;
        qe = qv;
        return {qe, ie};
    endfunction

    function automatic logic [31:0] header(int src, int seq);
        logic [31:0] h;
        h = 32'hA000_0000;
        if (src == 1) h[27] = 1'b1;
        h[23:16] = 8'(seq);
        h[7:0]   = 8'(PKT);
        return h;
    endfunction

    task automatic drive_inputs();
        int n;
        iq_empty  = (iq_q.size() == 0);
        iq_data   = iq_empty ? 24'h0 : iq_q[0];
        iq_enough = (iq_q.size() >= PKT);
        cpu_empty = (cpu_q.size() == 0);
        cpu_data  = cpu_empty ? 32'h0 : cpu_q[0];
        n = cpu_q.size() / PKT;
        cpu_blkcnt = (n > 15) ? 4'd15 : 4'(n);
    endtask

    task automatic model_reset();
        m_pos = -1; m_src = 0; m_starve = 0;
        m_seq[0] = 0; m_seq[1] = 0;
        m_underrun = 1'b0; m_done = 1'b0;
    endtask

    task automatic model_eval();
        logic e_iq, e_cpu;
        logic [1:0] e_gr;
        exp_data = 32'h0;
        if (m_pos == 0) exp_data = header(m_src, m_seq[m_src]);
        else if (m_pos > 0 && m_src == 1) exp_data = (cpu_q.size() > 0) ? cpu_q[0] : 32'h0;
        else if (m_pos > 0) exp_data = (iq_q.size() > 0) ? fmt_iq(iq_q[0]) : 32'h0;
        e_iq  = (m_pos > 0) && (m_src == 0) && ft_re && (iq_q.size() > 0);
        e_cpu = (m_pos > 0) && (m_src == 1) && ft_re && (cpu_q.size() > 0);
        e_gr  = (m_pos < 0) ? 2'b00 : ((m_src == 1) ? 2'b10 : 2'b01);
        exp_ctrl = {m_pos >= 0, e_gr, e_iq, e_cpu, m_done, m_underrun};
    endtask

    task automatic model_commit();
        logic iqp, cpup, empty;
        m_done = 1'b0;
        if (m_pos < 0) begin
            iqp  = cfg_iq_en && (iq_q.size() >= PKT);
            cpup = (cpu_q.size() >= PKT);
            if (iqp || cpup) begin
                m_src = (iqp && !(cpup && m_starve >= MAXB)) ? 0 : 1;
                m_pos = 0;
                if (m_src == 1) m_starve = 0;
                else if (cpup) m_starve = (m_starve >= 7) ? 7 : m_starve + 1;
            end
        end else if (m_pos == 0) begin
            if (ft_re) begin
                m_seq[m_src] = (m_seq[m_src] + 1) % 256;
                m_pos = 1;
            end
        end else begin
            empty = (m_src == 1) ? (cpu_q.size() == 0) : (iq_q.size() == 0);
            if (ft_re && empty) m_underrun = 1'b1;
            else if (ft_re && m_pos == PKT) begin
                m_pos = -1;
                m_done = (m_src == 1);
            end else if (ft_re) m_pos = m_pos + 1;
        end
    endtask

    task automatic cycle_eval();
        @(negedge clk);
        model_eval();
    endtask

    task automatic cycle_adv();
        logic pi, pc;
        model_commit();
        pi = iq_re;
        pc = cpu_re;
        @(posedge clk);
        #1;
        if (pi && iq_q.size() > 0) void'(iq_q.pop_front());
        if (pc && cpu_q.size() > 0) void'(cpu_q.pop_front());
        drive_inputs();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        ft_re = 1'b0;
        cfg_iq_en = 1'b1;
        b_iq_empty = 1'b0; b_iq_enough = 1'b0; b_cpu_empty = 1'b0;
        b_cpu_blkcnt = 4'd0; b_ft_re = 1'b0;
        iq_q.delete();
        cpu_q.delete();
        drive_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ft_re = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (act_ctrl !== 7'd0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want %b", act_ctrl, 7'd0);
        end
        n_cmp++;
        if (ft_data !== 32'h0) begin
            n_bad++; $display("FAIL reset_data: got %h want %h", ft_data, 32'h0);
        end
        apply_reset();
    endtask

    task automatic test_iq_only();
        logic [31:0] words[$];
        int pops = 0;
        logic [31:0] hdr2 = 32'h0;
        apply_reset();
        repeat (PKT) iq_q.push_back(24'h7FF800);
        drive_inputs();
        ft_re = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cycle_eval();
            n_cmp++;
            if (act_ctrl !== exp_ctrl) begin
                n_bad++; $display("FAIL iq_ctrl: got %b want %b", act_ctrl, exp_ctrl);
            end
            if (ft_avail) words.push_back(ft_data);
            if (iq_re) pops++;
            cycle_adv();
        end
        n_cmp++;
        if (words.size() != PKT + 1) begin
            n_bad++; $display("FAIL iq_len: got %0d want %0d", words.size(), PKT + 1);
        end else begin
            n_cmp++;
            if (words[0] !== 32'hA000_0004) begin
                n_bad++; $display("FAIL iq_hdr: got %h want %h", words[0], 32'hA000_0004);
            end
            for (int k = 1; k <= PKT; k++) begin
                n_cmp++;
                if (words[k] !== 32'h07FF_F800) begin
                    n_bad++; $display("FAIL iq_payload%0d: got %h want %h", k, words[k], 32'h07FF_F800);
                end
            end
        end
        n_cmp++;
        if (pops != PKT) begin
            n_bad++; $display("FAIL iq_pops: got %0d want %0d", pops, PKT);
        end
        repeat (PKT) iq_q.push_back(24'h123456);
        drive_inputs();
        for (int c = 0; c < 4; c++) begin
            cycle_eval();
            if (ft_avail && hdr2 == 32'h0) hdr2 = ft_data;
            cycle_adv();
        end
        n_cmp++;
        if (hdr2 !== 32'hA001_0004) begin
            n_bad++; $display("FAIL iq_seq1: got %h want %h", hdr2, 32'hA001_0004);
        end
    endtask

    task automatic test_priority();
        int order[$];
        int want[8] = '{1, 1, 2, 1, 1, 2, 1, 1};
        int dones = 0;
        logic prev = 1'b0;
        apply_reset();
        repeat (6 * PKT) iq_q.push_back(24'($urandom));
        repeat (2 * PKT) cpu_q.push_back($urandom);
        drive_inputs();
        ft_re = 1'b1;
        for (int c = 0; c < 70; c++) begin
            cycle_eval();
            n_cmp++;
            if (act_ctrl !== exp_ctrl) begin
                n_bad++; $display("FAIL prio_ctrl: got %b want %b", act_ctrl, exp_ctrl);
            end
            if (exp_ctrl[6]) begin
                n_cmp++;
                if (ft_data !== exp_data) begin
                    n_bad++; $display("FAIL prio_data: got %h want %h", ft_data, exp_data);
                end
            end
            if (ft_avail && !prev) order.push_back(int'(grant));
            prev = ft_avail;
            if (blk_done) dones++;
            cycle_adv();
        end
        n_cmp++;
        if (order.size() != 8) begin
            n_bad++; $display("FAIL prio_count: got %0d want %0d", order.size(), 8);
        end else begin
            for (int k = 0; k < 8; k++) begin
                n_cmp++;
                if (order[k] != want[k]) begin
                    n_bad++; $display("FAIL prio_order%0d: got %0d want %0d", k, order[k], want[k]);
                end
            end
        end
        n_cmp++;
        if (dones != 2) begin
            n_bad++; $display("FAIL prio_done: got %0d want %0d", dones, 2);
        end
    endtask

    task automatic test_strict();
        int pops = 0, dones = 0;
        logic found = 1'b0;
        apply_reset();
        b_cpu_blkcnt = 4'd1;
        b_iq_enough = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({b_avail, b_grant, b_data} !== {1'b1, 2'b10, 32'hA800_0004}) begin
            n_bad++; $display("FAIL strict_hdr: got %b/%b/%h want 1/10/a8000004", b_avail, b_grant, b_data);
        end
        b_ft_re = 1'b1;
        b_cpu_blkcnt = 4'd0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (b_cpu_re) pops++;
            if (b_done) dones++;
            if (b_grant == 2'b01) begin
                found = 1'b1;
                n_cmp++;
                if (b_data !== 32'hA000_0004) begin
                    n_bad++; $display("FAIL strict_iqhdr: got %h want %h", b_data, 32'hA000_0004);
                end
            end
        end
        n_cmp++;
        if (!found || pops != PKT || dones != 1) begin
            n_bad++; $display("FAIL strict_seq: got found=%0b pops=%0d dones=%0d want 1/%0d/1", found, pops, dones, PKT);
        end
        b_ft_re = 1'b0;
        b_iq_enough = 1'b0;
    endtask

    task automatic test_underrun();
        logic [23:0] stash[$];
        int pops = 0, hold = 0;
        logic stashed = 1'b0;
        apply_reset();
        repeat (PKT) iq_q.push_back(24'($urandom));
        drive_inputs();
        ft_re = 1'b1;
        for (int c = 0; c < 20; c++) begin
            cycle_eval();
            n_cmp++;
            if (act_ctrl !== exp_ctrl) begin
                n_bad++; $display("FAIL urun_ctrl: got %b want %b", act_ctrl, exp_ctrl);
            end
            if (exp_ctrl[6]) begin
                n_cmp++;
                if (ft_data !== exp_data) begin
                    n_bad++; $display("FAIL urun_data: got %h want %h", ft_data, exp_data);
                end
            end
            if (iq_re) pops++;
            cycle_adv();
            if (!stashed && m_pos == 3) begin
                stash = iq_q;
                iq_q.delete();
                stashed = 1'b1;
                hold = 3;
            end else if (stashed && hold > 0) begin
                hold--;
                if (hold == 0) iq_q = stash;
            end
            drive_inputs();
        end
        n_cmp++;
        if ({underrun, ft_avail} !== 2'b10 || pops != PKT) begin
            n_bad++; $display("FAIL urun_final: got urun=%b avail=%b pops=%0d want 1/0/%0d", underrun, ft_avail, pops, PKT);
        end
    endtask

    task automatic test_seq_wrap();
        int hdrs = 0;
        logic prev = 1'b0;
        logic [31:0] iqh = 32'h0;
        apply_reset();
        repeat (257 * PKT) cpu_q.push_back($urandom);
        drive_inputs();
        ft_re = 1'b1;
        for (int c = 0; c < 257 * (PKT + 2) + 20; c++) begin
            cycle_eval();
            n_cmp++;
            if (act_ctrl !== exp_ctrl) begin
                n_bad++; $display("FAIL wrap_ctrl: got %b want %b", act_ctrl, exp_ctrl);
            end
            if (exp_ctrl[6]) begin
                n_cmp++;
                if (ft_data !== exp_data) begin
                    n_bad++; $display("FAIL wrap_data: got %h want %h", ft_data, exp_data);
                end
            end
            if (ft_avail && !prev && grant == 2'b10) begin
                n_cmp++;
                if (ft_data[23:16] !== 8'(hdrs)) begin
                    n_bad++; $display("FAIL wrap_seq: got %h want %h", ft_data[23:16], 8'(hdrs));
                end
                hdrs++;
            end
            prev = ft_avail;
            cycle_adv();
        end
        n_cmp++;
        if (hdrs != 257) begin
            n_bad++; $display("FAIL wrap_count: got %0d want %0d", hdrs, 257);
        end
        repeat (PKT) iq_q.push_back(24'($urandom));
        drive_inputs();
        for (int c = 0; c < 4; c++) begin
            cycle_eval();
            if (ft_avail && iqh == 32'h0) iqh = ft_data;
            cycle_adv();
        end
        n_cmp++;
        if (iqh !== 32'hA000_0004) begin
            n_bad++; $display("FAIL wrap_iqseq: got %h want %h", iqh, 32'hA000_0004);
        end
    endtask

    task automatic test_reset_mid();
        logic found = 1'b0;
        logic [31:0] h = 32'h0;
        apply_reset();
        repeat (PKT) iq_q.push_back(24'($urandom));
        drive_inputs();
        ft_re = 1'b1;
        for (int c = 0; c < 10 && !found; c++) begin
            cycle_eval();
            cycle_adv();
            if (m_pos == 2) found = 1'b1;
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (!found || {ft_avail, grant} !== 3'b000) begin
            n_bad++; $display("FAIL rstmid_out: got found=%b avail=%b grant=%b want 1/0/00", found, ft_avail, grant);
        end
        iq_q.delete();
        model_reset();
        drive_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (PKT) iq_q.push_back(24'($urandom));
        drive_inputs();
        for (int c = 0; c < 4; c++) begin
            cycle_eval();
            if (ft_avail && h == 32'h0) h = ft_data;
            cycle_adv();
        end
        n_cmp++;
        if (h !== 32'hA000_0004) begin
            n_bad++; $display("FAIL rstmid_seq: got %h want %h", h, 32'hA000_0004);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            ft_re = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) cfg_iq_en = ~cfg_iq_en;
            if ($urandom_range(0, 9) == 0 && iq_q.size() < 64)
                repeat (PKT) iq_q.push_back(24'($urandom));
            if ($urandom_range(0, 14) == 0 && cpu_q.size() < 64)
                repeat (PKT) cpu_q.push_back($urandom);
            drive_inputs();
            cycle_eval();
            n_cmp++;
            if (act_ctrl !== exp_ctrl) begin
                n_bad++; $display("FAIL rnd_ctrl: cycle %0d got %b want %b", c, act_ctrl, exp_ctrl);
            end
            if (exp_ctrl[6]) begin
                n_cmp++;
                if (ft_data !== exp_data) begin
                    n_bad++; $display("FAIL rnd_data: cycle %0d got %h want %h", c, ft_data, exp_data);
                end
            end
            cycle_adv();
        end
    endtask

    initial begin
        rst = 1'b1;
        cfg_iq_en = 1'b1;
        ft_re = 1'b0;
        b_iq_empty = 1'b0; b_iq_enough = 1'b0; b_cpu_empty = 1'b0;
        b_cpu_blkcnt = 4'd0; b_ft_re = 1'b0;
        drive_inputs();
        model_reset();
        test_reset();
        test_iq_only();
        test_priority();
        test_strict();
        test_underrun();
        test_seq_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
